// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_elastic
//  Purpose  : Elastic inter-stage pipeline register. Carries a control bundle
//             and a payload across a valid/ready handshake using a 2-entry
//             skid buffer (main + skid slot). A flush turns every held entry
//             into a bubble with zeroed control bits. Saturating stall and
//             flush counters feed performance monitoring.
//  Ports    : clk, reset (async, active-high)
//             in_valid / in_ready / in_ctrl / in_data    upstream side
//             out_valid / out_ready / out_ctrl / out_data downstream side
//             flush                                      kill held entries
//             stall_cnt, flush_cnt                       perf counters
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 185,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;
    logic [CTRL_W-1:0]   w_main_ctrl_nxt;
    logic [DATA_W-1:0]   w_main_data_nxt;
    logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
    logic [DATA_W-1:0]   w_skid_data_nxt;

    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_stall_inc;

    // in_ready depends on state only, so no combinational path runs from
    // out_ready back upstream; the skid slot absorbs the extra entry.
    assign in_ready   = (r_state != ST_TWO) & ~reset;
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Gate control with valid so a bubble never asserts write/branch bits.
    assign out_ctrl   = out_valid ? r_main_ctrl : '0;
    assign out_data   = r_main_data;

    assign w_stall_inc = out_valid & ~out_ready & ~flush;

    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;

    // ------------------------------------------------------------------
    // Next-state and slot update logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;

        if (flush) begin
            // Held entries become bubbles; payload is left untouched so
            // out_data keeps its last value while empty.
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = '0;
            w_skid_ctrl_nxt = '0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt     = ST_ONE;
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end else if (w_in_xfer) begin
                        w_state_nxt     = ST_TWO;
                        w_skid_ctrl_nxt = in_ctrl;
                        w_skid_data_nxt = in_data;
                    end else if (w_out_xfer) begin
                        w_state_nxt     = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        w_state_nxt     = ST_ONE;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_main_data_nxt = r_skid_data;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State and slot registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_elastic
//  Purpose  : Self-checking bench for pipe_stage_elastic. A driver issues
//             directed and random stimulus and keeps a queue-based reference
//             of the held entries; a monitor pops and compares every entry
//             the DUT presents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_elastic;

    localparam int CW  = 9;
    localparam int DW  = 40;
    localparam int NW  = 4;
    localparam int MAXC = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic          flush = 1'b0;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] flush_cnt;

    pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference: ordered list of entries currently held, plus counters.
    logic [CW+DW-1:0] q[$];
    int               m_cnt   = 0;
    int               m_stall = 0;
    int               m_flush = 0;
    logic [DW-1:0]    last_head = '0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus with model update at the active edge.
    task automatic cyc(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit ordy, input bit fl);
        bit acc, oxf, stl;
        @(negedge clk);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #3;
        chk("in_ready",  64'(in_ready),  64'(m_cnt < 2));
        chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        acc = iv && (m_cnt < 2);
        oxf = (m_cnt > 0) && ordy;
        stl = (m_cnt > 0) && !ordy && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_cnt = 0;
            if (m_flush < MAXC) m_flush++;
        end else begin
            if (acc) q.push_back({c, d});
            m_cnt = m_cnt + int'(acc) - int'(oxf);
        end
        if (stl && m_stall < MAXC) m_stall++;
    endtask

    // Asynchronous reset applied between edges, with flush and in_valid
    // also high to show that reset dominates.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset    = 1'b1;
        flush    = 1'b1;
        in_valid = 1'b1;
        q.delete();
        m_cnt = 0; m_stall = 0; m_flush = 0;
        last_head = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_flush_ignored", 64'(flush_cnt), 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: compares the presented head against the reference queue.
    initial begin
        logic [CW+DW-1:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mon_unexpected: got data %0h expected no entry", out_data);
                end else begin
                    e = q[0];
                    chk("mon_ctrl", 64'(out_ctrl), 64'(e[CW+DW-1:DW]));
                    chk("mon_data", 64'(out_data), 64'(e[DW-1:0]));
                    last_head = e[DW-1:0];
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
                chk("hold_data",   64'(out_data), 64'(last_head));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r0, r1, r2;
        do_reset();

        // Streaming: 1..8 at full rate.
        for (int i = 1; i <= 8; i++) begin
            r0 = $urandom;
            cyc(1'b1, r0[CW-1:0], DW'(i), 1'b1, 1'b0);
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        #2 chk("stream_stall0", 64'(stall_cnt), 64'd0);

        // Backpressure into the skid slot.
        do_reset();
        cyc(1'b1, 9'h011, 40'hA, 1'b1, 1'b0);
        cyc(1'b1, 9'h022, 40'hB, 1'b0, 1'b0);
        #2 chk("skid_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        #2 chk("skid_stall4", 64'(stall_cnt), 64'd4);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        #2 chk("skid_ready_after_A", 64'(in_ready), 64'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while two entries are held; C must be discarded.
        do_reset();
        cyc(1'b1, 9'h1FF, 40'hA, 1'b0, 1'b0);
        cyc(1'b1, 9'h0AA, 40'hB, 1'b0, 1'b0);
        cyc(1'b1, 9'h155, 40'hC, 1'b0, 1'b1);
        #2;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("flush_cnt1",      64'(flush_cnt), 64'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        #2 chk("bubble_data_kept", 64'(out_data), 64'hA);

        // Reset mid-stream while full, then immediate acceptance.
        cyc(1'b1, 9'h003, 40'h11, 1'b0, 1'b0);
        cyc(1'b1, 9'h004, 40'h22, 1'b0, 1'b0);
        do_reset();
        cyc(1'b1, 9'h005, 40'hD, 1'b1, 1'b0);
        #2;
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data",  64'(out_data),  64'hD);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Saturation of both counters.
        do_reset();
        cyc(1'b1, 9'h007, 40'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
        #2 chk("stall_sat", 64'(stall_cnt), 64'(MAXC));
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b1, 1'b1);
        #2 chk("flush_sat", 64'(flush_cnt), 64'(MAXC));

        // Random traffic with occasional flush and reset.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if (i % 125 == 124) begin
                do_reset();
            end else begin
                r0 = $urandom;
                r1 = $urandom;
                r2 = $urandom;
                cyc(r2[0], r0[CW-1:0], {r0[31:24], r1},
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
            end
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
